// File: rtl/cloud_rom_pkg.sv
// Shared constants for the cloud sprite ROM arbiter.
// The optional output register stage is selected with CLOUD_ARB_RSP_REG_EN (see cloud_rom_arbiter).
package cloud_rom_pkg;

  // Sprite ROM geometry: 16K words of RGB444.
  localparam int unsigned CLOUD_ADDR_W = 14;
  localparam int unsigned CLOUD_DATA_W = 12;

  // Default number of cloud drawing units sharing the ROM.
  localparam int unsigned CLOUD_N_REQ = 4;

  // Width of the round-robin pointer / grant index for the default requester count.
  localparam int unsigned CLOUD_PTR_W = $clog2(CLOUD_N_REQ);

  // Pointer width for an arbitrary requester count; never narrower than one bit.
  function automatic int unsigned cloud_ptr_w(input int unsigned n_req);
    int unsigned w;
    w = $clog2(n_req);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cloud_rom_arbiter_rr_pick.sv
// rr_pick: purely combinational round-robin picker.
// Scans the request vector starting at index ptr, wrapping modulo N_REQ, and returns the first
// requester found as a one-hot grant plus its binary index.
module rr_pick
  import cloud_rom_pkg::*;
#(
  parameter int unsigned N_REQ = CLOUD_N_REQ,
  parameter int unsigned PTR_W = cloud_ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_any
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  localparam logic [PTR_W:0] NREQ_EXT = (PTR_W + 1)'(N_REQ);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // Walk the requesters in priority order from ptr; the first valid one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (sum >= NREQ_EXT) begin
        sum = sum - NREQ_EXT;
      end
      idx = sum[PTR_W-1:0];
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cloud_rom_arbiter.sv
// cloud_rom_arbiter: shares one single-port, one-cycle-latency sprite ROM between several cloud
// drawing units. One address transfer per cycle, granted round-robin; the ROM word comes back to
// the owning requester with a one-hot response strobe.
//
// Build option:
//   CLOUD_ARB_RSP_REG_EN  defined   -> extra output register, response latency 2
//                         undefined -> rsp_rgb passes rom_rgb straight through, latency 1
module cloud_rom_arbiter
  import cloud_rom_pkg::*;
#(
  parameter int unsigned N_REQ  = CLOUD_N_REQ,
  parameter int unsigned ADDR_W = CLOUD_ADDR_W,
  parameter int unsigned DATA_W = CLOUD_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  // One-cycle pulse at the start of each frame; restarts priority at requester 0.
  input  logic                    frame_start,
  // Requester side
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  // ROM side
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_rgb,
  // Response side (no back-pressure)
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rgb
);

  localparam int unsigned      PTR_W    = cloud_ptr_w(N_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [N_REQ-1:0] grant;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_any;
  logic [N_REQ-1:0] tag_q;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Grants only go to valid requesters, so every ready bit is a transfer.
  assign req_ready = grant;

  // Address mux: the one-hot grant selects a slice; zero when nothing is granted.
  always_comb begin
    rom_addr = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rom_addr = rom_addr | (req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{grant[i]}});
    end
  end

  // Next pointer: one past the winner, held when idle; frame_start wins over both.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
    end
    if (frame_start) begin
      ptr_d = '0;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // In-flight tag: which requester owns the word the ROM is producing this cycle.
  // Clearing it on reset drops any response still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q <= grant;
    end
  end

`ifdef CLOUD_ARB_RSP_REG_EN
  logic [N_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0] rsp_rgb_q;

  // Output stage: re-time the tag and ROM word together, adding one cycle of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_rgb_q   <= '0;
    end else begin
      rsp_valid_q <= tag_q;
      rsp_rgb_q   <= rom_rgb;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rgb   = rsp_rgb_q;
`else
  // ROM output is already registered, so the tag lines up with it directly.
  assign rsp_valid = tag_q;
  assign rsp_rgb   = rom_rgb;
`endif

endmodule

// File: tb/tb_cloud_rom_arbiter.sv
// Self-checking bench for cloud_rom_arbiter (default N_REQ=4). Honours CLOUD_ARB_RSP_REG_EN.
module tb_cloud_rom_arbiter;

`ifdef CLOUD_ARB_RSP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic [3:0]  req_valid;
  logic [55:0] req_addr;
  logic [3:0]  req_ready;
  logic [13:0] rom_addr;
  logic [11:0] rom_rgb;
  logic [3:0]  rsp_valid;
  logic [11:0] rsp_rgb;

  logic [13:0] a [4];
  assign req_addr = {a[3], a[2], a[1], a[0]};

  cloud_rom_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .rom_addr    (rom_addr),
    .rom_rgb     (rom_rgb),
    .rsp_valid   (rsp_valid),
    .rsp_rgb     (rsp_rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sprite ROM contents: a fixed scramble of the address.
  function automatic logic [11:0] rom_fn(input logic [13:0] ad);
    return ad[11:0] ^ {ad[13:12], ad[13:12], ad[13:12], 6'h15};
  endfunction

  // Single-port ROM with registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rom_rgb <= '0;
    else     rom_rgb <= rom_fn(rom_addr);
  end

  typedef struct packed {
    logic [3:0] valid;
    logic       fs;
    logic [3:0] exp_ready;
  } vec_t;

  typedef struct {
    int         due;
    logic [3:0] v;
    logic [11:0] rgb;
  } exp_t;

  vec_t tbl [22];
  exp_t sb [$];
  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic check_rsp();
    exp_t e;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'(e.v));
      if (e.v != 4'b0) chk("rsp_rgb", 32'(rsp_rgb), 32'(e.rgb));
    end
  endtask

  task automatic drive_check(input logic [3:0] v, input logic fs, input logic [3:0] exp_r);
    logic [13:0] exp_addr;
    @(negedge clk);
    req_valid   = v;
    frame_start = fs;
    #1;
    exp_addr = '0;
    for (int i = 0; i < 4; i++) if (exp_r[i]) exp_addr = a[i];
    chk("req_ready", 32'(req_ready), 32'(exp_r));
    chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
    sb.push_back('{due: cyc + LAT, v: exp_r, rgb: rom_fn(exp_addr)});
  endtask

  task automatic step(input logic [3:0] v, input logic fs, input logic [3:0] exp_r);
    drive_check(v, fs, exp_r);
    @(posedge clk);
    cyc++;
    #1;
    check_rsp();
  endtask

  initial begin
    // Expected grants are hand-derived from the pointer walk, starting at ptr=0.
    tbl[0]  = '{4'b0000, 1'b0, 4'b0000};  // idle
    tbl[1]  = '{4'b0100, 1'b0, 4'b0100};  // single requester 2, held three cycles
    tbl[2]  = '{4'b0100, 1'b0, 4'b0100};
    tbl[3]  = '{4'b0100, 1'b0, 4'b0100};
    tbl[4]  = '{4'b0000, 1'b1, 4'b0000};  // frame_start alone: ptr -> 0
    tbl[5]  = '{4'b1111, 1'b0, 4'b0001};  // all valid: 0,1,2,3,0
    tbl[6]  = '{4'b1111, 1'b0, 4'b0010};
    tbl[7]  = '{4'b1111, 1'b0, 4'b0100};
    tbl[8]  = '{4'b1111, 1'b0, 4'b1000};
    tbl[9]  = '{4'b1111, 1'b0, 4'b0001};
    tbl[10] = '{4'b1010, 1'b0, 4'b0010};  // ptr 1 -> 2
    tbl[11] = '{4'b1010, 1'b0, 4'b1000};  // ptr 2: 3 first
    tbl[12] = '{4'b1010, 1'b0, 4'b0010};  // then 1, ptr ends at 2
    tbl[13] = '{4'b0000, 1'b0, 4'b0000};  // idle holds ptr
    tbl[14] = '{4'b0101, 1'b0, 4'b0100};  // ptr still 2: requester 2 beats 0
    tbl[15] = '{4'b0011, 1'b0, 4'b0001};  // ptr 3 wraps to 0
    tbl[16] = '{4'b0100, 1'b0, 4'b0100};  // ptr -> 3
    tbl[17] = '{4'b1001, 1'b1, 4'b1000};  // frame_start while 3 granted, old ptr used
    tbl[18] = '{4'b1001, 1'b0, 4'b0001};  // requester 0 wins next
    tbl[19] = '{4'b0101, 1'b1, 4'b0100};  // grant 2 (ptr 1) but frame_start forces ptr 0
    tbl[20] = '{4'b1101, 1'b0, 4'b0001};  // 0 wins, not 3
    tbl[21] = '{4'b0000, 1'b0, 4'b0000};

    a[0] = 14'h0A5A;
    a[1] = 14'h1234;
    a[2] = 14'h0123;
    a[3] = 14'h2C3D;
    rst         = 1'b1;
    frame_start = 1'b0;
    req_valid   = 4'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset rsp_rgb", 32'(rsp_rgb), 32'h0);
    chk("reset req_ready", 32'(req_ready), 32'h0);
    chk("reset rom_addr", 32'(rom_addr), 32'h0);

    for (int i = 0; i < 22; i++) step(tbl[i].valid, tbl[i].fs, tbl[i].exp_ready);

    // Reset the cycle after accepting 0x3FFF from requester 1 (ptr 1 -> 2).
    a[1] = 14'h3FFF;
    drive_check(4'b0010, 1'b0, 4'b0010);
    @(posedge clk);
    cyc++;
    #1;
    rst       = 1'b1;
    req_valid = 4'b0;
    sb.delete();
    #1;
    chk("rst drop rsp_valid", 32'(rsp_valid), 32'h0);
    repeat (2) begin
      @(posedge clk);
      cyc++;
      #1;
      chk("rst hold rsp_valid", 32'(rsp_valid), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Restart from ptr 0: 0,1,2,3,0.
    step(4'b1111, 1'b0, 4'b0001);
    step(4'b1111, 1'b0, 4'b0010);
    step(4'b1111, 1'b0, 4'b0100);
    step(4'b1111, 1'b0, 4'b1000);
    step(4'b1111, 1'b0, 4'b0001);

    // Idle stretch also drains the scoreboard.
    repeat (10) step(4'b0000, 1'b0, 4'b0000);

    chk("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
